pio_led_fader: RTL and testbench



---
 rtl/pio_led_fader.sv | 107 ++++++++++
 tb/tb_pio_led_fader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pio_led_fader.sv
// pio_led_fader
//   Sits between the LED PIO out_port and the board LED pins. Each channel
//   ramps an 8-bit brightness level toward its target pattern bit on every
//   fade tick. The level is then rendered as 8-bit PWM.
//
//   Optional feature macro: PIO_LED_FADER_GAMMA_EN
//     When defined, duty = (level*level) >> 8, with level 255 forced to 255.
//     Otherwise, duty = level and no multiplier is built.
//
//   Parameters
//     WIDTH    number of LED channels
//     PRESCALE clocks per fade tick (>= 1)
//     STEP     level change per fade tick (1..255)
//
//   Ports
//     clk      system clock
//     reset_n  synchronous, active-low reset
//     led_in   target pattern, 1 = on
//     led_out  registered PWM LED drive
//     fading   registered; high while any level differs from its target
module pio_led_fader #(
    parameter int WIDTH    = 6,
    parameter int PRESCALE = 50000,
    parameter int STEP     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] led_in,
    output logic [WIDTH-1:0] led_out,
    output logic             fading
);

    localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [8:0]    STEP9     = 9'(STEP);

    logic [WIDTH-1:0] r_target_q;
    logic [PW-1:0]    r_presc;
    logic [7:0]       r_pwm_cnt;
    logic [7:0]       r_level [WIDTH];

    logic             w_tick;
    logic [7:0]       w_duty  [WIDTH];
    logic [WIDTH-1:0] w_led_next;
    logic             w_fading;

    // Saturating one-step move. The 9-bit intermediate exposes overflow
    // (sum > 255) and underflow (bit 8 set after borrow).
    function automatic logic [7:0] sat_step(input logic [7:0] lvl, input logic up);
        logic [8:0] t;
        if (up) begin
            t = {1'b0, lvl} + STEP9;
            return (t > 9'd255) ? 8'd255 : t[7:0];
        end else begin
            t = {1'b0, lvl} - STEP9;
            return t[8] ? 8'd0 : t[7:0];
        end
    endfunction

    function automatic logic [7:0] level_to_duty(input logic [7:0] lvl);
`ifdef PIO_LED_FADER_GAMMA_EN
        logic [15:0] sq;
        sq = 16'(lvl) * 16'(lvl);
        // 255*255>>8 is 254; full-on has to stay constant-on.
        return (lvl == 8'd255) ? 8'd255 : sq[15:8];
`else
        return lvl;
`endif
    endfunction

    assign w_tick = (r_presc == PRESC_MAX);

    always_comb begin
        w_led_next = '0;
        w_fading   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_duty[i]     = level_to_duty(r_level[i]);
            w_led_next[i] = (w_duty[i] == 8'd255) || (r_pwm_cnt < w_duty[i]);
            if (r_level[i] != (r_target_q[i] ? 8'd255 : 8'd0))
                w_fading = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_target_q <= '0;
            r_presc    <= '0;
            r_pwm_cnt  <= '0;
            led_out    <= '0;
            fading     <= 1'b0;
            for (int i = 0; i < WIDTH; i++)
                r_level[i] <= '0;
        end else begin
            r_target_q <= led_in;
            r_presc    <= w_tick ? '0 : r_presc + 1'b1;
            r_pwm_cnt  <= r_pwm_cnt + 8'd1;
            led_out    <= w_led_next;
            fading     <= w_fading;
            // Steps use the target registered before this edge, so a target
            // change coinciding with a tick takes effect on the next tick.
            for (int i = 0; i < WIDTH; i++)
                if (w_tick)
                    r_level[i] <= sat_step(r_level[i], r_target_q[i]);
        end
    end

endmodule

// File: tb/tb_pio_led_fader.sv
module tb_pio_led_fader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] led_a = 6'h3F, led_b = 6'h3F, led_c = 6'h3F;
    logic [5:0] out_a, out_b, out_c;
    logic       fad_a, fad_b, fad_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pio_led_fader #(.WIDTH(6), .PRESCALE(4),   .STEP(64))  dut_a (
        .clk(clk), .reset_n(reset_n), .led_in(led_a), .led_out(out_a), .fading(fad_a));
    pio_led_fader #(.WIDTH(6), .PRESCALE(4),   .STEP(200)) dut_b (
        .clk(clk), .reset_n(reset_n), .led_in(led_b), .led_out(out_b), .fading(fad_b));
    pio_led_fader #(.WIDTH(6), .PRESCALE(600), .STEP(64))  dut_c (
        .clk(clk), .reset_n(reset_n), .led_in(led_c), .led_out(out_c), .fading(fad_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lvl0(input int inst);
        case (inst)
            0:       return dut_a.r_level[0];
            1:       return dut_b.r_level[0];
            default: return dut_c.r_level[0];
        endcase
    endfunction

    // Waits (bounded) for level[0] of an instance to change; samples on negedge.
    task automatic wait_change(input int inst, input int bound,
                               output logic [7:0] val, output int cyc, output bit to);
        logic [7:0] prev;
        prev = lvl0(inst);
        to   = 1'b1;
        cyc  = 0;
        val  = prev;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (lvl0(inst) !== prev) begin
                val = lvl0(inst);
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic step_expect(input string tag, input int inst, input int bound,
                               input logic [7:0] exp, output int cyc);
        logic [7:0] v;
        bit         to;
        wait_change(inst, bound, v, cyc, to);
        check({tag, "_timeout"}, 32'(to), 32'd0);
        check(tag, 32'(v), 32'(exp));
    endtask

    // Counts led_out[0] high samples over one full 256-clock PWM period.
    task automatic pwm_count(input int inst, output int hi);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            case (inst)
                0:       hi += int'(out_a[0]);
                1:       hi += int'(out_b[0]);
                default: hi += int'(out_c[0]);
            endcase
        end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int         cyc;
        int         hi;
        int         exp64;
        int         exp128;
        logic [7:0] v;
        bit         to;

        // Reset held 3 clocks with all targets on.
        repeat (3) begin
            @(negedge clk);
            check("rst_led_out", 32'(out_a), 32'd0);
            check("rst_fading", 32'(fad_a), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_level_a", 32'(dut_a.r_level[0]), 32'd0);
        check("rel_level_a5", 32'(dut_a.r_level[5]), 32'd0);
        check("rel_out", 32'(out_a), 32'd0);

        // Ramp up, STEP=64, PRESCALE=4.
        led_a = 6'h00; led_b = 6'h00; led_c = 6'h00;
        do_reset(2);
        @(negedge clk);
        led_a = 6'h01;
        step_expect("ramp_64", 0, 10, 8'd64, cyc);
        step_expect("ramp_128", 0, 10, 8'd128, cyc);
        check("ramp_gap1", 32'(cyc), 32'd4);
        step_expect("ramp_192", 0, 10, 8'd192, cyc);
        check("ramp_gap2", 32'(cyc), 32'd4);
        step_expect("ramp_255", 0, 10, 8'd255, cyc);
        check("ramp_gap3", 32'(cyc), 32'd4);
        check("fading_hold", 32'(fad_a), 32'd1);
        @(negedge clk);
        check("fading_fall", 32'(fad_a), 32'd0);
        pwm_count(0, hi);
        check("full_on", 32'(hi), 32'd256);
        check("other_off", 32'(out_a[5:1]), 32'd0);

        // Reset asserted mid-ramp clears immediately.
        do_reset(2);
        @(negedge clk);
        led_a = 6'h01;
        step_expect("mid_64", 0, 10, 8'd64, cyc);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_level", 32'(dut_a.r_level[0]), 32'd0);
        check("midrst_fading", 32'(fad_a), 32'd0);
        check("midrst_out", 32'(out_a), 32'd0);

        // Reversal after 128.
        reset_n = 1'b1;
        step_expect("rev_64up", 0, 10, 8'd64, cyc);
        step_expect("rev_128", 0, 10, 8'd128, cyc);
        led_a = 6'h00;
        step_expect("rev_64dn", 0, 10, 8'd64, cyc);
        step_expect("rev_0", 0, 10, 8'd0, cyc);
        wait_change(0, 12, v, cyc, to);
        check("rev_settled", 32'(to), 32'd1);
        check("rev_fading", 32'(fad_a), 32'd0);

        // Saturation, STEP=200.
        do_reset(2);
        @(negedge clk);
        led_b = 6'h01;
        step_expect("sat_200", 1, 10, 8'd200, cyc);
        step_expect("sat_255", 1, 10, 8'd255, cyc);
        led_b = 6'h00;
        step_expect("sat_55", 1, 10, 8'd55, cyc);
        step_expect("sat_0", 1, 10, 8'd0, cyc);

        // PWM duty with long prescale so the level holds for a full period.
`ifdef PIO_LED_FADER_GAMMA_EN
        exp64 = 16; exp128 = 64;
`else
        exp64 = 64; exp128 = 128;
`endif
        do_reset(2);
        @(negedge clk);
        led_c = 6'h01;
        step_expect("pwm_lvl64", 2, 700, 8'd64, cyc);
        repeat (4) @(negedge clk);
        pwm_count(2, hi);
        check("pwm_duty64", 32'(hi), 32'(exp64));
        step_expect("pwm_lvl128", 2, 700, 8'd128, cyc);
        repeat (4) @(negedge clk);
        pwm_count(2, hi);
        check("pwm_duty128", 32'(hi), 32'(exp128));
        step_expect("pwm_lvl192", 2, 700, 8'd192, cyc);
        step_expect("pwm_lvl255", 2, 700, 8'd255, cyc);
        repeat (4) @(negedge clk);
        pwm_count(2, hi);
        check("pwm_duty255", 32'(hi), 32'd256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
